// File: rtl/alu_arbiter.sv
// Arbiter sharing one ALU among N_REQ cores: IDLE -> ISSUE -> WAIT -> DONE per operation.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_arbiter #(
  parameter int N_REQ   = 8,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rslt,
  output logic                    rslt_z,
  output logic                    busy,
  output logic                    alu_rst,
  output logic                    alu_enable,
  output logic [OP_W-1:0]         alu_opcode,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_c,
  input  logic                    alu_z
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   start;
  logic               any_req;
  logic [OP_W-1:0]    sel_op;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;

  // First set bit at or after s, wrapping; scanning downward leaves the closest hit.
  function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDX_W-1:0] s);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(s) + k) % N_REQ);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign alu_rst = ~rst;
  assign any_req = |req;
  assign winner  = pick(req, start);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (state == IDLE && any_req) begin
      ptr <= (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  assign start = ptr;
`endif

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      done       <= '0;
      rslt       <= '0;
      rslt_z     <= 1'b0;
      busy       <= 1'b0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      done       <= '0;
      alu_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= winner;
            alu_opcode <= sel_op;
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(ALU_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rslt   <= alu_c;
            rslt_z <= alu_z;
            done   <= N_REQ'(1) << grant;
            state  <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a one-cycle-latency ALU model attached.
module tb_alu_arbiter;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*OW-1:0] req_op = '0;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N-1:0]  done;
  logic [DW-1:0] rslt;
  logic          rslt_z;
  logic          busy;
  logic          alu_rst;
  logic          alu_enable;
  logic [OW-1:0] alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_c;
  logic          alu_z;

  typedef struct {
    int            core;
    logic [DW-1:0] r;
    logic          z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .done(done), .rslt(rslt), .rslt_z(rslt_z), .busy(busy), .alu_rst(alu_rst),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_z(alu_z)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_rst) begin
      alu_c <= '0;
      alu_z <= 1'b0;
    end else if (alu_enable) begin
      alu_c <= alu_f(alu_opcode, alu_a, alu_b);
      alu_z <= (alu_f(alu_opcode, alu_a, alu_b) == '0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic post(input int c, input logic [OW-1:0] op,
                      input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_op[c*OW +: OW] = op;
    req_a[c*DW +: DW]  = a;
    req_b[c*DW +: DW]  = b;
    req[c]             = 1'b1;
  endtask

  task automatic expect_op(input int c, input logic [OW-1:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e.core = c;
    e.r    = alu_f(op, a, b);
    e.z    = (e.r == '0);
    sb.push_back(e);
  endtask

  task automatic post_exp(input int c, input logic [OW-1:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    post(c, op, a, b);
    expect_op(c, op, a, b);
  endtask

  // One clock: sample on the falling edge, score any done pulse, drop the finished request.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (done != '0) begin
      done_cnt++;
      check("done_onehot", $countones(done), 1);
      if (sb.size() == 0) begin
        check("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("done_vec", done, N'(1) << e.core);
        check("rslt", rslt, e.r);
        check("rslt_z", rslt_z, e.z);
      end
      req = req & ~done;
    end
  endtask

  initial begin
    int dc;

    // Reset state
    repeat (3) step();
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_en", alu_enable, 0);
    check("rst_rslt", rslt, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_rst", alu_rst, 1);
    rst = 1'b1;
    step();
    check("alu_rst_rel", alu_rst, 0);

    // Fairness: all eight held high, grant order 0..7 every 4 cycles
    for (int k = 0; k < N; k++) begin
      post_exp(k, OW'(k % 4), DW'(1000 * k + 7), DW'(3 * k + 1));
    end
    for (int k = 0; k < N; k++) begin
      repeat ((k == 0) ? 3 : 4) step();
      check("rr_grant", done, N'(1) << k);
    end
    step();

    // Pointer back at 0 after core 7: cores 7 and 0 together, 0 wins
    post(7, 2'd0, 16'd100, 16'd1);
    post(0, 2'd0, 16'd200, 16'd2);
    expect_op(0, 2'd0, 16'd200, 16'd2);
    expect_op(7, 2'd0, 16'd100, 16'd1);
    repeat (3) step();
    check("wrap_first", done, 8'h01);
    repeat (4) step();
    check("wrap_second", done, 8'h80);
    step();

    // Single add on core 2
    post_exp(2, 2'd0, 16'd6304, 16'd1843);
    step();
    check("add_en_c1", alu_enable, 1);
    check("add_busy_c1", busy, 1);
    check("add_alu_a", alu_a, 6304);
    check("add_alu_b", alu_b, 1843);
    check("add_alu_op", alu_opcode, 0);
    step();
    check("add_en_c2", alu_enable, 0);
    check("add_busy_c2", busy, 1);
    step();
    check("add_done", done, 8'h04);
    check("add_rslt", rslt, 8147);
    check("add_z", rslt_z, 0);
    check("add_en_c3", alu_enable, 0);
    step();
    check("add_done_clr", done, 0);
    check("add_busy_idle", busy, 0);
    check("add_rslt_hold", rslt, 8147);

    // Zero flag
    post_exp(0, 2'd1, 16'd45, 16'd45);
    repeat (3) step();
    check("z_done", done, 8'h01);
    check("z_rslt", rslt, 0);
    check("z_flag", rslt_z, 1);
    step();

    // Contention after wrap: move pointer to 6 via a grant to core 5
    post_exp(5, 2'd2, 16'hF0F0, 16'h3C3C);
    repeat (4) step();
    post(1, 2'd0, 16'd11, 16'd22);
    post(6, 2'd3, 16'h1234, 16'h00FF);
`ifdef ALU_ARB_FIXED_PRIO_EN
    expect_op(1, 2'd0, 16'd11, 16'd22);
    expect_op(6, 2'd3, 16'h1234, 16'h00FF);
    repeat (3) step();
    check("cont_first", done, 8'h02);
    repeat (4) step();
    check("cont_second", done, 8'h40);
`else
    expect_op(6, 2'd3, 16'h1234, 16'h00FF);
    expect_op(1, 2'd0, 16'd11, 16'd22);
    repeat (3) step();
    check("cont_first", done, 8'h40);
    repeat (4) step();
    check("cont_second", done, 8'h02);
`endif
    step();

    // Reset during WAIT: aborted op produces no done; held req is granted after release
    post(3, 2'd0, 16'd9, 16'd9);
    repeat (2) step();
    check("mid_busy_wait", busy, 1);
    rst = 1'b0;
    dc = done_cnt;
    step();
    check("mid_busy", busy, 0);
    check("mid_en", alu_enable, 0);
    check("mid_rslt", rslt, 0);
    check("mid_alu_rst", alu_rst, 1);
    check("mid_done", done, 0);
    step();
    check("mid_no_done", done_cnt - dc, 0);
    rst = 1'b1;
    expect_op(3, 2'd0, 16'd9, 16'd9);
    repeat (3) step();
    check("mid_regrant", done, 8'h08);
    step();

    // Late arrival during ISSUE of core 5
    post_exp(5, 2'd1, 16'd500, 16'd123);
    step();
    check("late_en", alu_enable, 1);
    post_exp(3, 2'd0, 16'd40, 16'd2);
    repeat (2) step();
    check("late_first", done, 8'h20);
    repeat (4) step();
    check("late_second", done, 8'h08);
    step();

    // Request dropped during WAIT still completes exactly once
    dc = done_cnt;
    post_exp(4, 2'd3, 16'hAAAA, 16'h5555);
    repeat (2) step();
    req[4] = 1'b0;
    step();
    check("drop_done", done, 8'h10);
    repeat (6) step();
    check("drop_once", done_cnt - dc, 1);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one 16-bit ALU among the eight cores of the matrix-multiplication processor. Each core posts an opcode and two operands with a request. The arbiter serialises the requests onto the ALU's enable/opcode/A/B buses, waits out the ALU latency, and returns the result and zero flag to the winning core with a one-cycle done pulse.

## Interface
- `N_REQ`, 8: number of requesting cores.
- `DATA_W`, 16: operand/result width.
- `OP_W`, 2: ALU opcode width.
- `ALU_LAT`, 1: cycles from the ALU enable edge to a valid `alu_c`; must be ≥1.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req` in N_REQ: per-core request level.
- `req_op` in N_REQ*OP_W: flattened opcodes; core i occupies bits [i*OP_W +: OP_W].
- `req_a` in N_REQ*DATA_W: flattened A operands; same slicing as `req_op`.
- `req_b` in N_REQ*DATA_W: flattened B operands; same slicing as `req_op`.
- `done` out N_REQ: one-hot, single-cycle completion pulse.
- `rslt` out DATA_W: result, broadcast to all cores, valid while any `done` bit is high.
- `rslt_z` out 1: captured ALU zero flag, valid with `rslt`.
- `busy` out 1: high in every state except IDLE.
- `alu_rst` out 1: ALU reset, active-high; equals `~rst` combinationally.
- `alu_enable` out 1: ALU enable.
- `alu_opcode` out OP_W: opcode to the ALU.
- `alu_a` out DATA_W: A operand to the ALU.
- `alu_b` out DATA_W: B operand to the ALU.
- `alu_c` in DATA_W: ALU result.
- `alu_z` in 1: ALU zero flag.

## Operation
- FSM states and transitions:
  - IDLE: with no request, stay in IDLE. With any `req` bit high, select a winner, latch the winner's op/a/b into the `alu_*` registers, and go to ISSUE.
  - ISSUE: `alu_enable`=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay `ALU_LAT` cycles, counted by a down-counter loaded at ISSUE. On the last WAIT cycle, capture `alu_c`→`rslt` and `alu_z`→`rslt_z`, then go to DONE.
  - DONE: `done[winner]`=1 for one cycle, then go to IDLE.
- Round-robin pointer `ptr` (reset value 0):
  - The search starts at index `ptr` and wraps modulo N_REQ; the first set `req` bit wins.
  - After a grant to core i, `ptr` becomes (i+1) mod N_REQ; at i=N_REQ-1 it wraps to 0.
  - `ptr` only moves on a grant.
- `alu_opcode`/`alu_a`/`alu_b` hold the latched values from ISSUE until the next grant. Opcode values are passed through unchecked, including undefined opcodes.
- Requester rules:
  - Hold `req` and operands stable until `done[i]` is seen.
  - Drop `req` on the edge where `done[i]` is high.
  - `req` still high in the cycle after DONE is a new request.
- Requests that drop mid-operation are ignored: the operation completes and `done` still pulses.
- Requests that arrive outside IDLE are not lost; they are arbitrated at the next IDLE.
- Reset, at any state including mid-operation, takes effect on the next edge with no `done` pulse:
  - state=IDLE, `ptr`=0, WAIT counter=0;
  - `done`=0, `rslt`=0, `rslt_z`=0, `busy`=0;
  - `alu_enable`=0, `alu_opcode`=0, `alu_a`=0, `alu_b`=0;
  - `alu_rst`=1 while `rst`=0.

## Timing
- `req[i]` sampled high in IDLE at cycle 0 gives: ISSUE in cycle 1, WAIT in cycles 2..ALU_LAT+1, `done[i]` in cycle ALU_LAT+2. The default is cycle 3.
- Back-to-back throughput is one operation per ALU_LAT+3 cycles (4 by default), including the mandatory IDLE cycle.
- `rslt`/`rslt_z` stay valid from DONE until the next capture.
- `busy` is registered and rises in ISSUE.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `ptr` is not implemented and the search always starts at 0.
  - Undefined (default): round-robin as described in Operation.
- Latency and the handshake are identical in both builds.

## Test plan
- Single request, add: core 2 drives op=0, A=6304, B=1843 at cycle 0 → `done`=8'b0000_0100 at cycle 3, `rslt`=8147, `rslt_z`=0; `alu_enable` high only in cycle 1.
- Zero flag: core 0 drives op=1, A=45, B=45 → `done[0]` at cycle 3, `rslt`=0, `rslt_z`=1.
- Round-robin fairness: all 8 `req` held high, each core dropping `req` at its own `done` → grant order 0,1,…,7. A `done` pulse every 4 cycles, first at cycle 3. After core 7, `ptr`=0.
- Contention after wrap: `ptr`=6 with cores 1 and 6 requesting → core 6 granted first, then core 1. Under `ALU_ARB_FIXED_PRIO_EN` the same stimulus grants core 1 first.
- Reset mid-operation: assert `rst`=0 during WAIT → next cycle state=IDLE, `busy`=0, `alu_enable`=0, `rslt`=0, `alu_rst`=1. No `done` pulse appears. After release, a held `req` is granted normally.
- Late and dropped requests: core 3 raises `req` during core 5's ISSUE → core 3 granted in the IDLE after core 5's DONE. Core 4 drops `req` during WAIT → `done[4]` still pulses once.
